// File: rtl/multicycle_control_pkg.sv
// Shared definitions for the multicycle MIPS-style controller.
// Holds the supported opcodes, the 4-bit state encodings, and the
// encodings driven onto aluOp, ALUSrcB and PCSource.
package multicycle_control_pkg;

  // Instruction opcodes, bits [31:26] of the instruction word.
  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_J     = 6'b000010;
  localparam logic [5:0] OP_ADDI  = 6'b001000;

  // Encodings 12..15 are unused and recover to S_FETCH.
  typedef enum logic [3:0] {
    S_FETCH  = 4'd0,
    S_DECODE = 4'd1,
    S_MEMADR = 4'd2,
    S_MEMRD  = 4'd3,
    S_MEMWB  = 4'd4,
    S_MEMWR  = 4'd5,
    S_EXEC   = 4'd6,
    S_ALUWB  = 4'd7,
    S_BRANCH = 4'd8,
    S_JUMP   = 4'd9,
    S_ADDIEX = 4'd10,
    S_ADDIWB = 4'd11
  } state_e;

  typedef enum logic [1:0] {
    ALUOP_ADD   = 2'b00,
    ALUOP_SUB   = 2'b01,
    ALUOP_FUNCT = 2'b10
  } aluop_e;

  typedef enum logic [1:0] {
    ALUSRCB_REG   = 2'b00,
    ALUSRCB_FOUR  = 2'b01,
    ALUSRCB_IMM   = 2'b10,
    ALUSRCB_IMMSH = 2'b11
  } alusrcb_e;

  // ALU result (PC+4), registered ALUOut (branch target), jump target.
  typedef enum logic [1:0] {
    PCSRC_ALU    = 2'b00,
    PCSRC_ALUOUT = 2'b01,
    PCSRC_JUMP   = 2'b10
  } pcsrc_e;

endpackage

// File: rtl/multicycle_control_outdec.sv
// Combinational output decoder for the multicycle controller.
// Ports:
//   state_i      current FSM state
//   mem_ready_i  memory handshake (only affects FETCH strobes)
//   rst_i        synchronous reset; forces every output to 0
//   *_o          datapath strobes and mux selects
import multicycle_control_pkg::*;

module multicycle_control_outdec (
  input  logic [3:0] state_i,
  input  logic       mem_ready_i,
  input  logic       rst_i,
  output logic       pc_write_o,
  output logic       pc_write_cond_o,
  output logic       iord_o,
  output logic       mem_read_o,
  output logic       mem_write_o,
  output logic       mem_to_reg_o,
  output logic       ir_write_o,
  output logic       alu_src_a_o,
  output logic       reg_write_o,
  output logic       reg_dst_o,
  output logic [1:0] pc_source_o,
  output logic [1:0] alu_src_b_o,
  output logic [1:0] alu_op_o
);

  always_comb begin
    // NOTE: every output gets a default before the case so no path leaves
    // a signal unassigned; that is what keeps this block free of latches.
    pc_write_o      = 1'b0;
    pc_write_cond_o = 1'b0;
    iord_o          = 1'b0;
    mem_read_o      = 1'b0;
    mem_write_o     = 1'b0;
    mem_to_reg_o    = 1'b0;
    ir_write_o      = 1'b0;
    alu_src_a_o     = 1'b0;
    reg_write_o     = 1'b0;
    reg_dst_o       = 1'b0;
    pc_source_o     = PCSRC_ALU;
    alu_src_b_o     = ALUSRCB_REG;
    alu_op_o        = ALUOP_ADD;

    if (!rst_i) begin
      case (state_i)
        S_FETCH: begin
          mem_read_o  = 1'b1;
          alu_src_b_o = ALUSRCB_FOUR;
          // The only Mealy outputs: latch the instruction and advance the PC
          // in the same cycle the read completes.
          ir_write_o  = mem_ready_i;
          pc_write_o  = mem_ready_i;
        end
        S_DECODE: alu_src_b_o = ALUSRCB_IMMSH;
        S_MEMADR: begin
          alu_src_a_o = 1'b1;
          alu_src_b_o = ALUSRCB_IMM;
        end
        S_MEMRD: begin
          mem_read_o = 1'b1;
          iord_o     = 1'b1;
        end
        S_MEMWB: begin
          mem_to_reg_o = 1'b1;
          reg_write_o  = 1'b1;
        end
        S_MEMWR: begin
          mem_write_o = 1'b1;
          iord_o      = 1'b1;
        end
        S_EXEC: begin
          alu_src_a_o = 1'b1;
          alu_op_o    = ALUOP_FUNCT;
        end
        S_ALUWB: begin
          reg_dst_o   = 1'b1;
          reg_write_o = 1'b1;
        end
        S_BRANCH: begin
          alu_src_a_o     = 1'b1;
          alu_op_o        = ALUOP_SUB;
          pc_write_cond_o = 1'b1;
          pc_source_o     = PCSRC_ALUOUT;
        end
        S_JUMP: begin
          pc_write_o  = 1'b1;
          pc_source_o = PCSRC_JUMP;
        end
        S_ADDIEX: begin
          alu_src_a_o = 1'b1;
          alu_src_b_o = ALUSRCB_IMM;
        end
        S_ADDIWB: reg_write_o = 1'b1;
        default: ;
      endcase
    end
  end

endmodule

// File: rtl/multicycle_control.sv
// Multicycle MIPS-style main controller.
// Ports:
//   clk, rst        clock and synchronous active-high reset
//   opcode          instruction bits [31:26] (sampled in DECODE/MEMADR only)
//   mem_ready       memory completion handshake (FETCH/MEMRD/MEMWR only)
//   PCWrite..aluOp  datapath strobes and selects (from the output decoder)
//   illegal_op      one-cycle pulse after DECODE sees an unsupported opcode
//   retired         wrapping count of completed instructions
//   state_dbg       current state encoding
import multicycle_control_pkg::*;

module multicycle_control #(
  parameter int CNT_W = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [5:0]       opcode,
  input  logic             mem_ready,
  output logic             PCWrite,
  output logic             PCWriteCond,
  output logic             IorD,
  output logic             MemRead,
  output logic             MemWrite,
  output logic             MemtoReg,
  output logic             IRWrite,
  output logic             ALUSrcA,
  output logic             RegWrite,
  output logic             RegDst,
  output logic [1:0]       PCSource,
  output logic [1:0]       ALUSrcB,
  output logic [1:0]       aluOp,
  output logic             illegal_op,
  output logic [CNT_W-1:0] retired,
  output logic [3:0]       state_dbg
);

  state_e           state_q, state_d;
  logic             illegal_q, illegal_d;
  logic [CNT_W-1:0] retired_q;
  logic             retire;

  always_comb begin
    state_d   = state_q;
    illegal_d = 1'b0;
    retire    = 1'b0;
    case (state_q)
      S_FETCH:  if (mem_ready) state_d = S_DECODE;
      S_DECODE: begin
        case (opcode)
          OP_LW, OP_SW: state_d = S_MEMADR;
          OP_RTYPE:     state_d = S_EXEC;
          OP_BEQ:       state_d = S_BRANCH;
          OP_J:         state_d = S_JUMP;
          OP_ADDI:      state_d = S_ADDIEX;
          default: begin
            // Abandon the instruction without retiring it.
            state_d   = S_FETCH;
            illegal_d = 1'b1;
          end
        endcase
      end
      S_MEMADR: state_d = (opcode == OP_LW) ? S_MEMRD : S_MEMWR;
      S_MEMRD:  if (mem_ready) state_d = S_MEMWB;
      S_MEMWR: begin
        if (mem_ready) begin
          state_d = S_FETCH;
          retire  = 1'b1;
        end
      end
      S_EXEC:   state_d = S_ALUWB;
      S_ADDIEX: state_d = S_ADDIWB;
      S_MEMWB, S_ALUWB, S_BRANCH, S_JUMP, S_ADDIWB: begin
        state_d = S_FETCH;
        retire  = 1'b1;
      end
      default:  state_d = S_FETCH;
    endcase
  end

  // NOTE: sequential state is updated with non-blocking assignments so every
  // register samples the pre-edge values, independent of statement order.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= S_FETCH;
      illegal_q <= 1'b0;
      retired_q <= '0;
    end else begin
      state_q   <= state_d;
      illegal_q <= illegal_d;
      if (retire) retired_q <= retired_q + CNT_W'(1);
    end
  end

  multicycle_control_outdec u_outdec (
    .state_i         (state_q),
    .mem_ready_i     (mem_ready),
    .rst_i           (rst),
    .pc_write_o      (PCWrite),
    .pc_write_cond_o (PCWriteCond),
    .iord_o          (IorD),
    .mem_read_o      (MemRead),
    .mem_write_o     (MemWrite),
    .mem_to_reg_o    (MemtoReg),
    .ir_write_o      (IRWrite),
    .alu_src_a_o     (ALUSrcA),
    .reg_write_o     (RegWrite),
    .reg_dst_o       (RegDst),
    .pc_source_o     (PCSource),
    .alu_src_b_o     (ALUSrcB),
    .alu_op_o        (aluOp)
  );

  // Every output reads as zero / FETCH while reset is held.
  assign illegal_op = illegal_q & ~rst;
  assign retired    = rst ? '0 : retired_q;
  assign state_dbg  = rst ? S_FETCH : state_q;

endmodule

// File: tb/tb_multicycle_control.sv
// Scoreboard bench for multicycle_control (CNT_W=4 so the counter wraps).
// The stimulus process drives one cycle at a time and queues the outputs
// expected during that cycle; the monitor pops and compares on the falling edge.
module tb_multicycle_control;

  localparam int CW = 4;

  localparam logic [5:0] LW = 6'b100011, SW = 6'b101011, RT = 6'b000000;
  localparam logic [5:0] BEQ = 6'b000100, JMP = 6'b000010, ADDI = 6'b001000;
  localparam logic [5:0] BAD = 6'b111111;

  localparam logic [3:0] FETCH = 4'd0, DECODE = 4'd1, MEMADR = 4'd2, MEMRD = 4'd3;
  localparam logic [3:0] MEMWB = 4'd4, MEMWR = 4'd5, EXEC = 4'd6, ALUWB = 4'd7;
  localparam logic [3:0] BRANCH = 4'd8, JUMP = 4'd9, ADDIEX = 4'd10, ADDIWB = 4'd11;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic [5:0]    opcode = LW;
  logic          mem_ready = 1'b1;
  logic          PCWrite, PCWriteCond, IorD, MemRead, MemWrite, MemtoReg;
  logic          IRWrite, ALUSrcA, RegWrite, RegDst;
  logic [1:0]    PCSource, ALUSrcB, aluOp;
  logic          illegal_op;
  logic [CW-1:0] retired;
  logic [3:0]    state_dbg;

  multicycle_control #(.CNT_W(CW)) dut (
    .clk(clk), .rst(rst), .opcode(opcode), .mem_ready(mem_ready),
    .PCWrite(PCWrite), .PCWriteCond(PCWriteCond), .IorD(IorD),
    .MemRead(MemRead), .MemWrite(MemWrite), .MemtoReg(MemtoReg),
    .IRWrite(IRWrite), .ALUSrcA(ALUSrcA), .RegWrite(RegWrite), .RegDst(RegDst),
    .PCSource(PCSource), .ALUSrcB(ALUSrcB), .aluOp(aluOp),
    .illegal_op(illegal_op), .retired(retired), .state_dbg(state_dbg)
  );

  always #5 clk = ~clk;

  typedef struct {
    string         tag;
    logic [3:0]    state;
    logic [15:0]   strb;
    logic          ill;
    logic [CW-1:0] ret;
  } exp_t;

  exp_t          sb_q[$];
  int            n_checks = 0;
  int            n_pass = 0;
  int            cyc = 0;
  logic [CW-1:0] exp_ret = '0;
  logic          pend_ill = 1'b0;
  string         cur_tag = "reset";

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
  endtask

  // Packed order: PCWrite PCWriteCond IorD MemRead MemWrite MemtoReg IRWrite
  //               ALUSrcA RegWrite RegDst PCSource[1:0] ALUSrcB[1:0] aluOp[1:0]
  function automatic logic [15:0] sv(input logic pcw, pcwc, iord, mrd, mwr, m2r,
                                     irw, asa, rw, rd, input logic [1:0] pcs, asb, aop);
    return {pcw, pcwc, iord, mrd, mwr, m2r, irw, asa, rw, rd, pcs, asb, aop};
  endfunction

  // Hand-written strobe table, one row per state.
  function automatic logic [15:0] exp_strb(input logic [3:0] st, input logic mr);
    case (st)
      FETCH:  return sv(mr, 0, 0, 1, 0, 0, mr, 0, 0, 0, 2'b00, 2'b01, 2'b00);
      DECODE: return sv(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 2'b00, 2'b11, 2'b00);
      MEMADR: return sv(0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 2'b00, 2'b10, 2'b00);
      MEMRD:  return sv(0, 0, 1, 1, 0, 0, 0, 0, 0, 0, 2'b00, 2'b00, 2'b00);
      MEMWB:  return sv(0, 0, 0, 0, 0, 1, 0, 0, 1, 0, 2'b00, 2'b00, 2'b00);
      MEMWR:  return sv(0, 0, 1, 0, 1, 0, 0, 0, 0, 0, 2'b00, 2'b00, 2'b00);
      EXEC:   return sv(0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 2'b00, 2'b00, 2'b10);
      ALUWB:  return sv(0, 0, 0, 0, 0, 0, 0, 0, 1, 1, 2'b00, 2'b00, 2'b00);
      BRANCH: return sv(0, 1, 0, 0, 0, 0, 0, 1, 0, 0, 2'b01, 2'b00, 2'b01);
      JUMP:   return sv(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 2'b10, 2'b00, 2'b00);
      ADDIEX: return sv(0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 2'b00, 2'b10, 2'b00);
      ADDIWB: return sv(0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 2'b00, 2'b00, 2'b00);
      default: return 16'h0000;
    endcase
  endfunction

  // Drive one cycle of inputs and queue the outputs expected in that cycle.
  task automatic step(input logic [5:0] op, input logic mr, input logic r, input logic [3:0] st);
    exp_t e;
    @(posedge clk);
    #1;
    opcode = op; mem_ready = mr; rst = r;
    cyc++;
    e.tag   = $sformatf("%s c%0d", cur_tag, cyc);
    e.state = r ? FETCH : st;
    e.strb  = r ? 16'h0000 : exp_strb(st, mr);
    e.ill   = r ? 1'b0 : pend_ill;
    e.ret   = r ? '0 : exp_ret;
    sb_q.push_back(e);
    pend_ill = 1'b0;
    if (r) exp_ret = '0;
  endtask

  // One instruction: fw / mw wait cycles in FETCH / memory state; omr is the
  // mem_ready value driven in states that must ignore it.
  task automatic instr(input string name, input logic [5:0] op, input int fw, input int mw,
                       input logic omr);
    cur_tag = name;
    for (int i = 0; i < fw; i++) step(op, 1'b0, 1'b0, FETCH);
    step(op, 1'b1, 1'b0, FETCH);
    step(op, omr, 1'b0, DECODE);
    case (op)
      LW: begin
        step(op, omr, 1'b0, MEMADR);
        for (int i = 0; i < mw; i++) step(op, 1'b0, 1'b0, MEMRD);
        step(op, 1'b1, 1'b0, MEMRD);
        step(op, omr, 1'b0, MEMWB);
        exp_ret++;
      end
      SW: begin
        step(op, omr, 1'b0, MEMADR);
        for (int i = 0; i < mw; i++) step(op, 1'b0, 1'b0, MEMWR);
        step(op, 1'b1, 1'b0, MEMWR);
        exp_ret++;
      end
      RT:   begin step(op, omr, 1'b0, EXEC); step(op, omr, 1'b0, ALUWB); exp_ret++; end
      BEQ:  begin step(op, omr, 1'b0, BRANCH); exp_ret++; end
      JMP:  begin step(op, omr, 1'b0, JUMP); exp_ret++; end
      ADDI: begin step(op, omr, 1'b0, ADDIEX); step(op, omr, 1'b0, ADDIWB); exp_ret++; end
      default: pend_ill = 1'b1;
    endcase
  endtask

  // Monitor: compare DUT outputs against the oldest queued expectation.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (sb_q.size() > 0) begin
        e = sb_q.pop_front();
        check({e.tag, " state"}, 32'(state_dbg), 32'(e.state));
        check({e.tag, " strobes"},
              32'({PCWrite, PCWriteCond, IorD, MemRead, MemWrite, MemtoReg, IRWrite,
                   ALUSrcA, RegWrite, RegDst, PCSource, ALUSrcB, aluOp}), 32'(e.strb));
        check({e.tag, " illegal_op"}, 32'(illegal_op), 32'(e.ill));
        check({e.tag, " retired"}, 32'(retired), 32'(e.ret));
      end
    end
  end

  initial begin
    // Reset held two cycles with a lw opcode and mem_ready high.
    step(LW, 1'b1, 1'b1, FETCH);
    step(LW, 1'b1, 1'b1, FETCH);

    // Back-to-back instructions, mem_ready tied high: 5,4,4,3,3,4 cycles.
    instr("lw",   LW,   0, 0, 1'b1);
    instr("sw",   SW,   0, 0, 1'b1);
    instr("rtype", RT,  0, 0, 1'b1);
    instr("beq",  BEQ,  0, 0, 1'b1);
    instr("j",    JMP,  0, 0, 1'b1);
    instr("addi", ADDI, 0, 0, 1'b1);

    // lw with 3 FETCH and 2 MEMRD wait states (10 cycles); mem_ready low
    // elsewhere to show it is ignored outside the handshake states.
    instr("lw_wait", LW, 3, 2, 1'b0);

    // Illegal opcode: pulse appears in the following FETCH, no retire.
    instr("illegal", BAD, 0, 0, 1'b1);

    // sw reset while stalled in MEMWR.
    cur_tag = "sw_rst";
    step(SW, 1'b1, 1'b0, FETCH);
    step(SW, 1'b1, 1'b0, DECODE);
    step(SW, 1'b1, 1'b0, MEMADR);
    step(SW, 1'b0, 1'b0, MEMWR);
    step(SW, 1'b0, 1'b1, MEMWR);

    // 17 jumps from a freshly reset counter: 4-bit count wraps to 1.
    for (int i = 0; i < 17; i++) instr($sformatf("j_wrap%0d", i), JMP, 0, 0, 1'b1);
    cur_tag = "final";
    step(JMP, 1'b0, 1'b0, FETCH);

    @(negedge clk);
    #1;
    if (sb_q.size() != 0) check("scoreboard drain", 32'(sb_q.size()), 32'd0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
